// File: rtl/sync_filter_multi_if.sv
// sync_filter_multi_if: groups the per-channel conditioner signals.
// master = the side that drives raw pins and flag clears.
// slave  = the conditioner itself.
// Level semantics only, with no valid/ready handshake:
// - async_in may change at any time.
// - clr_flag is sampled on every posedge.
// - Every output is a registered level or a registered single-cycle pulse.
`timescale 1ns/10ps
interface sync_filter_multi_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] async_in;
   logic [WIDTH-1:0] clr_flag;
   logic [WIDTH-1:0] sync_out;
   logic [WIDTH-1:0] filt_out;
   logic [WIDTH-1:0] rise_pulse;
   logic [WIDTH-1:0] fall_pulse;
   logic [WIDTH-1:0] chg_flag;

   modport master (
      output async_in, clr_flag,
      input  sync_out, filt_out, rise_pulse, fall_pulse, chg_flag
   );

   modport slave (
      input  async_in, clr_flag,
      output sync_out, filt_out, rise_pulse, fall_pulse, chg_flag
   );
endinterface

// File: rtl/sync_filter_multi.sv
// sync_filter_multi: multi-channel input conditioner.
// Each channel passes through the following steps:
// - an N-flop synchronizer;
// - a consecutive-sample glitch filter;
// - registered rise/fall pulses on the filtered level;
// - a sticky change flag with a synchronous clear.
// The filter holds a per-channel run counter. The filtered level moves only after
// FILTER_LEN consecutive synchronized samples disagree with it.
`timescale 1ns/10ps
module sync_filter_multi #(
   parameter int               WIDTH      = 4,
   parameter int               STAGES     = 2,
   parameter logic [WIDTH-1:0] RESET_VAL  = '0,
   parameter int               FILTER_LEN = 3
) (
   input  logic                clk,
   input  logic                n_rst,
   sync_filter_multi_if.slave  bus
);

   localparam int             CW      = $clog2(FILTER_LEN + 1);
   localparam logic [CW-1:0]  CNT_MAX = CW'(FILTER_LEN - 1);

   logic [WIDTH-1:0] sync_q [STAGES];
   logic [WIDTH-1:0] filt_q;
   logic [WIDTH-1:0] rise_q;
   logic [WIDTH-1:0] fall_q;
   logic [WIDTH-1:0] chg_q;
   logic [CW-1:0]    cnt_q [WIDTH];
   logic [WIDTH-1:0] sync_now;
   logic [WIDTH-1:0] upd;

   assign sync_now = sync_q[STAGES-1];

   // Shift the raw pins through the synchronizer chain, one stage per clock
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int s = 0; s < STAGES; s++) sync_q[s] <= RESET_VAL;
      end else begin
         sync_q[0] <= bus.async_in;
         for (int s = 1; s < STAGES; s++) sync_q[s] <= sync_q[s-1];
      end
   end

   // A channel updates when it disagrees and has already seen FILTER_LEN-1 disagreeing samples
   always_comb begin
      upd = '0;
      for (int i = 0; i < WIDTH; i++) begin
         upd[i] = (sync_now[i] != filt_q[i]) && (cnt_q[i] == CNT_MAX);
      end
   end

   // Run counters: restart on agreement or on the accepting sample, otherwise count up
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if ((sync_now[i] == filt_q[i]) || (cnt_q[i] == CNT_MAX)) begin
               cnt_q[i] <= '0;
            end else begin
               cnt_q[i] <= cnt_q[i] + 1'b1;
            end
         end
      end
   end

   // Filtered level, edge pulses and sticky flags are all updated in the same edge
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         filt_q <= RESET_VAL;
         rise_q <= '0;
         fall_q <= '0;
         chg_q  <= '0;
      end else begin
         // upd implies sync_now differs from filt_q, so toggling adopts sync_now
         filt_q <= filt_q ^ upd;
         rise_q <= upd & sync_now;
         fall_q <= upd & ~sync_now;
         // Setting wins over a same-cycle clear
         chg_q  <= (chg_q & ~bus.clr_flag) | upd;
      end
   end

   assign bus.sync_out   = sync_now;
   assign bus.filt_out   = filt_q;
   assign bus.rise_pulse = rise_q;
   assign bus.fall_pulse = fall_q;
   assign bus.chg_flag   = chg_q;

endmodule

// File: tb/tb_sync_filter_multi.sv
// tb_sync_filter_multi: directed bench for sync_filter_multi.
// dut_a uses the default depths. dut_b uses STAGES=3 and FILTER_LEN=1.
// Both duts have RESET_VAL=4'b0101.
// Inputs change on the negedge, or close to a posedge for the window case.
`timescale 1ns/10ps
module tb_sync_filter_multi;

   logic tb_clk;
   logic n_rst;
   int   n_cmp;
   int   n_err;

   sync_filter_multi_if #(.WIDTH(4)) bus_a ();
   sync_filter_multi_if #(.WIDTH(4)) bus_b ();

   sync_filter_multi #(
      .WIDTH(4), .STAGES(2), .RESET_VAL(4'b0101), .FILTER_LEN(3)
   ) dut_a (
      .clk(tb_clk), .n_rst(n_rst), .bus(bus_a)
   );

   sync_filter_multi #(
      .WIDTH(4), .STAGES(3), .RESET_VAL(4'b0101), .FILTER_LEN(1)
   ) dut_b (
      .clk(tb_clk), .n_rst(n_rst), .bus(bus_b)
   );

   // clock / reset block
   initial tb_clk = 1'b0;
   always #5 tb_clk = ~tb_clk;

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge tb_clk);
   endtask

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_sync_a"}, bus_a.sync_out,   4'b0101);
      check({tag, "_filt_a"}, bus_a.filt_out,   4'b0101);
      check({tag, "_rise_a"}, bus_a.rise_pulse, 4'b0000);
      check({tag, "_fall_a"}, bus_a.fall_pulse, 4'b0000);
      check({tag, "_chg_a"},  bus_a.chg_flag,   4'b0000);
      check({tag, "_sync_b"}, bus_b.sync_out,   4'b0101);
      check({tag, "_filt_b"}, bus_b.filt_out,   4'b0101);
      check({tag, "_chg_b"},  bus_b.chg_flag,   4'b0000);
   endtask

   task automatic clear_flags_a();
      bus_a.clr_flag = 4'hF;
      tick(1);
      bus_a.clr_flag = 4'h0;
      check("clr_all", bus_a.chg_flag, 4'b0000);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      n_rst = 1'b1;
      bus_a.async_in = 4'h0;
      bus_a.clr_flag = 4'h0;
      bus_b.async_in = 4'b0101;
      bus_b.clr_flag = 4'h0;

      // 1: reset asserted mid-cycle takes effect at once
      #3;
      bus_a.async_in = 4'hF;
      n_rst = 1'b0;
      #1;
      check_reset_state("rst_now");
      tick(2);
      check_reset_state("rst_2clk");
      n_rst = 1'b1;
      tick(1);
      check_reset_state("rst_rel1");

      // 2: step to 4'hF, sync after 2 posedges, filt after 5
      tick(1);
      check("step_sync2",  bus_a.sync_out,   4'hF);
      check("step_filt2",  bus_a.filt_out,   4'b0101);
      tick(2);
      check("step_filt4",  bus_a.filt_out,   4'b0101);
      check("step_rise4",  bus_a.rise_pulse, 4'b0000);
      tick(1);
      check("step_filt5",  bus_a.filt_out,   4'hF);
      check("step_rise5",  bus_a.rise_pulse, 4'b1010);
      check("step_fall5",  bus_a.fall_pulse, 4'b0000);
      check("step_chg5",   bus_a.chg_flag,   4'b1010);
      tick(1);
      check("step_rise6",  bus_a.rise_pulse, 4'b0000);
      check("step_chg6",   bus_a.chg_flag,   4'b1010);
      clear_flags_a();

      // drop ch0 so the glitch case starts from a low level
      bus_a.async_in = 4'hE;
      tick(4);
      check("drop0_filt4", bus_a.filt_out,   4'hF);
      tick(1);
      check("drop0_filt5", bus_a.filt_out,   4'hE);
      check("drop0_fall5", bus_a.fall_pulse, 4'b0001);
      check("drop0_chg5",  bus_a.chg_flag,   4'b0001);
      clear_flags_a();

      // 3: two-cycle glitch on ch0 is rejected
      bus_a.async_in = 4'hF;
      tick(2);
      check("glitch_sync_hi1", bus_a.sync_out, 4'hF);
      bus_a.async_in = 4'hE;
      tick(1);
      check("glitch_sync_hi2", bus_a.sync_out, 4'hF);
      for (int k = 0; k < 6; k++) begin
         tick(1);
         check("glitch_filt", bus_a.filt_out,   4'hE);
         check("glitch_rise", bus_a.rise_pulse, 4'b0000);
         check("glitch_chg",  bus_a.chg_flag,   4'b0000);
      end

      // 3: three-cycle pulse on ch0 passes, then falls back
      bus_a.async_in = 4'hF;
      tick(3);
      bus_a.async_in = 4'hE;
      tick(2);
      check("pass3_filt",  bus_a.filt_out,   4'hF);
      check("pass3_rise",  bus_a.rise_pulse, 4'b0001);
      check("pass3_chg",   bus_a.chg_flag,   4'b0001);
      tick(1);
      check("pass3_rise_off", bus_a.rise_pulse, 4'b0000);
      tick(2);
      check("pass3_fall_filt", bus_a.filt_out,   4'hE);
      check("pass3_fall",      bus_a.fall_pulse, 4'b0001);
      clear_flags_a();

      // 4: ch2 toggles 0.05 ns before a posedge
      #4.95;
      bus_a.async_in = 4'hA;
      tick(1);
      tick(2);
      check("setup_sync",  bus_a.sync_out,   4'hA);
      tick(2);
      check("setup_filt",  bus_a.filt_out,   4'hA);
      check("setup_fall",  bus_a.fall_pulse, 4'b0100);

      // 4: ch2 toggles 0.05 ns after a posedge
      @(posedge tb_clk);
      #0.05;
      bus_a.async_in = 4'hE;
      tick(1);
      tick(2);
      check("hold_sync",   bus_a.sync_out,   4'hE);
      tick(3);
      check("hold_filt",   bus_a.filt_out,   4'hE);
      check("hold_rise",   bus_a.rise_pulse, 4'b0100);
      clear_flags_a();

      // 5: clear coinciding with a set loses, next-cycle clear wins
      bus_a.async_in = 4'hC;
      tick(5);
      check("race_pre_filt", bus_a.filt_out,   4'hC);
      check("race_pre_fall", bus_a.fall_pulse, 4'b0010);
      clear_flags_a();
      bus_a.async_in = 4'hE;
      tick(4);
      bus_a.clr_flag = 4'b0010;
      tick(1);
      check("race_rise",   bus_a.rise_pulse, 4'b0010);
      check("race_chg_set", bus_a.chg_flag,  4'b0010);
      tick(1);
      check("race_chg_clr", bus_a.chg_flag,  4'b0000);
      bus_a.clr_flag = 4'h0;

      // 6: reset while ch3 is two samples into a change
      bus_a.async_in = 4'h6;
      tick(4);
      check("midf_filt",   bus_a.filt_out,   4'hE);
      #2;
      n_rst = 1'b0;
      bus_a.async_in = 4'b0101;
      #1;
      check_reset_state("midf_rst");
      tick(1);
      n_rst = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick(1);
         check("midf_rise_a", bus_a.rise_pulse, 4'b0000);
         check("midf_fall_a", bus_a.fall_pulse, 4'b0000);
         check("midf_filt_a", bus_a.filt_out,   4'b0101);
         check("midf_rise_b", bus_b.rise_pulse, 4'b0000);
         check("midf_fall_b", bus_b.fall_pulse, 4'b0000);
      end

      // 6: STAGES=3, FILTER_LEN=1 gives a 4-posedge latency
      bus_b.async_in = 4'hF;
      tick(3);
      check("b_sync3",     bus_b.sync_out,   4'hF);
      check("b_filt3",     bus_b.filt_out,   4'b0101);
      tick(1);
      check("b_filt4",     bus_b.filt_out,   4'hF);
      check("b_rise4",     bus_b.rise_pulse, 4'b1010);
      check("b_chg4",      bus_b.chg_flag,   4'b1010);
      tick(1);
      check("b_rise5",     bus_b.rise_pulse, 4'b0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
